// File: rtl/regfile_wb_sched_if.sv
// regfile_wb_sched_if: issue, writeback request and register-file port signals of the writeback scheduler
interface regfile_wb_sched_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                 iss_valid;
  logic [ADDR_W-1:0]    iss_dest;
  logic [ADDR_W-1:0]    iss_src_a;
  logic [ADDR_W-1:0]    iss_src_b;
  logic                 iss_stall;
  logic                 req0_valid;
  logic [ADDR_W-1:0]    req0_dest;
  logic [DATA_W-1:0]    req0_data;
  logic                 req0_ready;
  logic                 req1_valid;
  logic [ADDR_W-1:0]    req1_dest;
  logic [DATA_W-1:0]    req1_data;
  logic                 req1_ready;
  logic                 rf_load;
  logic [ADDR_W-1:0]    rf_dest;
  logic [DATA_W-1:0]    rf_in;
  logic [2**ADDR_W-1:0] busy;
  modport master (
    output iss_valid, iss_dest, iss_src_a, iss_src_b,
    output req0_valid, req0_dest, req0_data, req1_valid, req1_dest, req1_data,
    input  iss_stall, req0_ready, req1_ready, rf_load, rf_dest, rf_in, busy
  );
  modport slave (
    input  iss_valid, iss_dest, iss_src_a, iss_src_b,
    input  req0_valid, req0_dest, req0_data, req1_valid, req1_dest, req1_data,
    output iss_stall, req0_ready, req1_ready, rf_load, rf_dest, rf_in, busy
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: two-source writeback arbiter and RAW/WAW scoreboard for a 2**ADDR_W register file.
// WB_RR_ARB_EN selects round-robin arbitration; otherwise req0 has fixed priority.
module regfile_wb_sched #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic               clk,
  input logic               rst,
  regfile_wb_sched_if.slave bus
);
  localparam int N = 2**ADDR_W;
  logic              r_load;
  logic [ADDR_W-1:0] r_dest;
  logic [DATA_W-1:0] r_in;
  logic [N-1:0]      r_busy;
  logic              w_g0, w_g1;
  logic [N-1:0]      w_hz, w_set, w_clr;
  logic              w_stall;
`ifdef WB_RR_ARB_EN
  logic r_last;
  assign w_g0 = bus.req0_valid && (!bus.req1_valid || r_last);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_last <= 1'b1;
    else if (w_g0 || w_g1) r_last <= w_g1;
`else
  assign w_g0 = bus.req0_valid;
`endif
  assign w_g1 = bus.req1_valid && !w_g0;
  // a register written this cycle is bypassed by the register file, so it is no hazard
  assign w_clr = (r_load && r_dest != '0) ? (N'(1) << r_dest) : '0;
  assign w_hz = r_busy & ~w_clr;
  assign w_stall = bus.iss_valid && (w_hz[bus.iss_src_a] || w_hz[bus.iss_src_b] || w_hz[bus.iss_dest]);
  assign w_set = (bus.iss_valid && !w_stall && bus.iss_dest != '0) ? (N'(1) << bus.iss_dest) : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_load <= 1'b0;
      r_dest <= '0;
      r_in <= '0;
      r_busy <= '0;
    end else begin
      r_load <= w_g0 || w_g1;
      if (w_g0 || w_g1) begin
        r_dest <= w_g0 ? bus.req0_dest : bus.req1_dest;
        r_in <= w_g0 ? bus.req0_data : bus.req1_data;
      end
      r_busy <= ((r_busy & ~w_clr) | w_set) & ~N'(1);
    end
  assign bus.req0_ready = w_g0;
  assign bus.req1_ready = w_g1;
  assign bus.iss_stall = w_stall;
  assign bus.rf_load = r_load;
  assign bus.rf_dest = r_dest;
  assign bus.rf_in = r_in;
  assign bus.busy = r_busy;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb_regfile_wb_sched: directed vectors for the writeback scheduler, arbitration expectations follow WB_RR_ARB_EN.
module tb_regfile_wb_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  regfile_wb_sched_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  regfile_wb_sched #(.DATA_W(32), .ADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.iss_valid = 0; bus.iss_dest = 0; bus.iss_src_a = 0; bus.iss_src_b = 0;
    bus.req0_valid = 0; bus.req0_dest = 0; bus.req0_data = 0;
    bus.req1_valid = 0; bus.req1_dest = 0; bus.req1_data = 0;
  endtask
  initial begin
    bit rr;
`ifdef WB_RR_ARB_EN
    rr = 1;
`else
    rr = 0;
`endif
    idle();
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_load", bus.rf_load, 0);
    chk("rst_dest", bus.rf_dest, 0);
    chk("rst_in", bus.rf_in, 0);
    rst = 0;
    bus.req0_valid = 1; bus.req0_dest = 5; bus.req0_data = 32'hDEADBEEF;
    #1;
    chk("w1_rdy0", bus.req0_ready, 1);
    chk("w1_rdy1", bus.req1_ready, 0);
    step();
    bus.req0_valid = 0;
    chk("w1_load", bus.rf_load, 1);
    chk("w1_dest", bus.rf_dest, 5);
    chk("w1_in", bus.rf_in, 32'hDEADBEEF);
    step();
    chk("w1_idle", bus.rf_load, 0);
    chk("w1_hold", bus.rf_in, 32'hDEADBEEF);
    chk("w1_busy", bus.busy, 0);
    bus.req1_valid = 1; bus.req1_dest = 9; bus.req1_data = 32'h1234;
    #1;
    chk("w2_rdy1", bus.req1_ready, 1);
    step();
    chk("w2_dest", bus.rf_dest, 9);
    bus.req0_valid = 1; bus.req0_dest = 1; bus.req0_data = 32'hA0;
    bus.req1_valid = 1; bus.req1_dest = 2; bus.req1_data = 32'hB1;
    for (int i = 0; i < 4; i++) begin
      automatic bit g0 = !rr || (i % 2 == 0);
      #1;
      chk($sformatf("ct%0d_rdy0", i), bus.req0_ready, g0);
      chk($sformatf("ct%0d_rdy1", i), bus.req1_ready, !g0);
      step();
      chk($sformatf("ct%0d_dest", i), bus.rf_dest, g0 ? 1 : 2);
      chk($sformatf("ct%0d_in", i), bus.rf_in, g0 ? 32'hA0 : 32'hB1);
    end
    idle();
    step();
    bus.iss_valid = 1; bus.iss_dest = 7;
    #1;
    chk("raw_iss7", bus.iss_stall, 0);
    step();
    chk("raw_busy7", bus.busy, 32'h80);
    bus.iss_dest = 8; bus.iss_src_a = 7;
    #1;
    chk("raw_stall", bus.iss_stall, 1);
    step();
    chk("raw_stall2", bus.iss_stall, 1);
    chk("raw_noset", bus.busy, 32'h80);
    bus.req0_valid = 1; bus.req0_dest = 7; bus.req0_data = 32'h77;
    #1;
    chk("raw_stall3", bus.iss_stall, 1);
    step();
    bus.req0_valid = 0;
    chk("raw_byp_load", bus.rf_load, 1);
    chk("raw_bypass", bus.iss_stall, 0);
    step();
    chk("raw_busy8", bus.busy, 32'h100);
    bus.iss_valid = 0;
    #1;
    chk("noval_stall", bus.iss_stall, 0);
    bus.iss_valid = 1; bus.iss_dest = 3; bus.iss_src_a = 0;
    step();
    chk("sc_busy3", bus.busy, 32'h108);
    bus.iss_valid = 0;
    bus.req0_valid = 1; bus.req0_dest = 3; bus.req0_data = 32'h33;
    step();
    bus.req0_valid = 0;
    bus.iss_valid = 1; bus.iss_dest = 3;
    #1;
    chk("sc_stall", bus.iss_stall, 0);
    step();
    chk("sc_setwins", bus.busy, 32'h108);
    bus.iss_dest = 0; bus.iss_src_a = 0;
    #1;
    chk("x0_stall", bus.iss_stall, 0);
    step();
    chk("x0_busy", bus.busy, 32'h108);
    bus.iss_valid = 0;
    bus.req0_valid = 1; bus.req0_dest = 0; bus.req0_data = 32'h55;
    step();
    chk("x0_load", bus.rf_load, 1);
    chk("x0_dest", bus.rf_dest, 0);
    chk("x0_in", bus.rf_in, 32'h55);
    chk("x0_busy2", bus.busy, 32'h108);
    bus.req0_dest = 4; bus.req0_data = 32'h44;
    #1;
    chk("ar_rdy", bus.req0_ready, 1);
    rst = 1;
    #1;
    chk("ar_busy", bus.busy, 0);
    chk("ar_load", bus.rf_load, 0);
    chk("ar_dest", bus.rf_dest, 0);
    idle();
    #1;
    rst = 0;
    step();
    chk("ar_discard", bus.rf_load, 0);
    bus.req0_valid = 1; bus.req1_valid = 1; bus.req1_dest = 2;
    #1;
    chk("ar_first0", bus.req0_ready, 1);
    chk("ar_first1", bus.req1_ready, 0);
    idle();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
